// File: rtl/mdu_iter_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Funct3 op encodings, FSM state encoding and the per-step datapath mode.
package mdu_iter_pkg;

  localparam int MDU_XLEN     = 32;
  localparam int MDU_REG_SIZE = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Operand a is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring).
// acc holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
module mdu_step
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  step_mode_e          mode,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     operand_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Partial remainder shifted left needs one extra bit before the trial subtract.
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    trial   = rem_sh - {1'b0, operand_i};
    acc_o   = '0;
    if (mode == STEP_MUL) begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (32 steps) -> DONE -> IDLE.
// Define ZCRV_MDU_FAST_MUL_EN for a single-cycle multiplier; divides stay iterative.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    md_from_id,
  input  logic [2:0]              op_from_id,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [MDU_REG_SIZE-1:0] rd_from_id,
  output logic                    busy_to_stall,
  output logic                    finish_to_stall,
  output logic [MDU_REG_SIZE-1:0] rd_to_stall,
  output logic                    wb_en,
  output logic [XLEN-1:0]         wb_data,
  output logic [1:0]              state_dbg
);

  mdu_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  mdu_op_e                 op_q, op_d;
  logic [MDU_REG_SIZE-1:0] rd_q, rd_d;
  logic                    sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0]       acc_q, acc_d;
  logic [XLEN-1:0]         operand_q, operand_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;
  logic                    busy_q, busy_d, finish_q, finish_d, wb_en_q, wb_en_d;

  step_mode_e        step_mode;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_result;
  logic              a_neg, b_neg, is_dz, is_ovf;
  logic [XLEN-1:0]   a_abs, b_abs;

  assign step_mode = op_q[2] ? STEP_DIV : STEP_MUL;

  mdu_step #(.XLEN(XLEN)) u_step (
    .mode      (step_mode),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (acc_next)
  );

  // Magnitudes are computed unsigned; the sign is restored once at the end.
  assign prod_fix = (sa_q ^ sb_q) ? -acc_next : acc_next;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
  assign rem_fix  = sa_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

  always_comb begin
    calc_result = '0;
    unique case (op_q)
      OP_MUL:                    calc_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:           calc_result = quo_fix;
      default:                   calc_result = rem_fix;
    endcase
  end

  assign a_neg  = op_a_signed(op_from_id) && rs1_data[XLEN-1];
  assign b_neg  = op_b_signed(op_from_id) && rs2_data[XLEN-1];
  assign a_abs  = a_neg ? -rs1_data : rs1_data;
  assign b_abs  = b_neg ? -rs2_data : rs2_data;
  assign is_dz  = op_from_id[2] && (rs2_data == '0);
  assign is_ovf = ((op_from_id == OP_DIV) || (op_from_id == OP_REM)) &&
                  (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

`ifdef ZCRV_MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic [2*XLEN-1:0]        fast_low;
  assign fast_prod = $signed({op_a_signed(op_from_id) & rs1_data[XLEN-1], rs1_data}) *
                     $signed({op_b_signed(op_from_id) & rs2_data[XLEN-1], rs2_data});
  assign fast_low  = fast_prod[2*XLEN-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (md_from_id) begin
          op_d  = mdu_op_e'(op_from_id);
          rd_d  = rd_from_id;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          if (is_dz) begin
            wb_data_d = op_from_id[1] ? rs1_data : '1;
            state_d   = ST_DONE;
          end else if (is_ovf) begin
            wb_data_d = op_from_id[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d   = ST_DONE;
`ifdef ZCRV_MDU_FAST_MUL_EN
          end else if (!op_from_id[2]) begin
            wb_data_d = (op_from_id == OP_MUL) ? fast_low[XLEN-1:0] : fast_low[2*XLEN-1:XLEN];
            state_d   = ST_DONE;
`endif
          end else begin
            acc_d     = op_from_id[2] ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
            operand_d = op_from_id[2] ? b_abs : a_abs;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          cnt_d     = '0;
          wb_data_d = calc_result;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d != ST_IDLE);
    finish_d = (state_d == ST_DONE);
    wb_en_d  = finish_d && (rd_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      acc_q     <= '0;
      operand_q <= '0;
      wb_data_q <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
      wb_en_q   <= wb_en_d;
    end
  end

  assign busy_to_stall   = busy_q;
  assign finish_to_stall = finish_q;
  assign rd_to_stall     = rd_q;
  assign wb_en           = wb_en_q;
  assign wb_data         = wb_data_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, random ops against
// an arithmetic reference model, plus pulse/hold/reset sequences.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

`ifdef ZCRV_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  rd = '0;
  logic        busy, fin, wb_en;
  logic [4:0]  rd_o;
  logic [31:0] wb_data;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mdu_iter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .md_from_id      (md),
    .op_from_id      (op),
    .rs1_data        (a),
    .rs2_data        (b),
    .rd_from_id      (rd),
    .busy_to_stall   (busy),
    .finish_to_stall (fin),
    .rd_to_stall     (rd_o),
    .wb_en           (wb_en),
    .wb_data         (wb_data),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 64-bit and native signed arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint px, py;
    logic [63:0] p;
    int sx, sy;
    sx = x;
    sy = y;
    p  = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin px = sx; py = sy; p = px * py; return p[63:32]; end
      3'd2: begin px = sx; py = longint'({32'b0, y}); p = px * py; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) return MUL_LAT;
    if (y == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op; optionally hold md high throughout, or pulse a foreign op mid-flight.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp,
                        input int exp_lat, input bit hold_md, input int pulse_at);
    int lat;
    bit seen;
    exp_q.push_back(exp);
    @(negedge clk);
    md = 1'b1; op = f; a = x; b = y; rd = r;
    @(posedge clk);
    #1;
    if (!hold_md) md = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (pulse_at != 0 && k == pulse_at) begin
        md = 1'b1; op = ~f; a = ~x; b = y + 32'd3; rd = ~r;
      end else if (pulse_at != 0 && k == pulse_at + 1) begin
        md = 1'b0;
      end
      if (fin) begin
        seen = 1'b1;
        lat = k;
      end else if (!busy) begin
        chk({name, " busy_in_flight"}, 32'(busy), 32'd1);
      end
    end
    chk({name, " finish_seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " wb_data"}, wb_data, exp_q.pop_front());
    chk({name, " rd"}, 32'(rd_o), 32'(r));
    chk({name, " wb_en"}, 32'(wb_en), 32'(r != 5'd0));
    chk({name, " busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({name, " idle_after"}, {30'd0, busy, fin}, 32'd0);
    md = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  r;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"mul_7x6",        3'd0, 32'd7,          32'd6,          5'd3,  32'd42,         MUL_LAT});
    vecs.push_back('{"mulh_min_min",   3'd1, 32'h8000_0000,  32'h8000_0000,  5'd4,  32'h4000_0000,  MUL_LAT});
    vecs.push_back('{"mulhu_max",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE,  MUL_LAT});
    vecs.push_back('{"mulhsu_m1x2",    3'd2, 32'hFFFF_FFFF,  32'd2,          5'd6,  32'hFFFF_FFFF,  MUL_LAT});
    vecs.push_back('{"div_m7_2",       3'd4, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33});
    vecs.push_back('{"rem_m7_2",       3'd6, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  33});
    vecs.push_back('{"divu_100_7",     3'd5, 32'd100,        32'd7,          5'd9,  32'd14,         33});
    vecs.push_back('{"remu_100_7",     3'd7, 32'd100,        32'd7,          5'd10, 32'd2,          33});
    vecs.push_back('{"divu_by0",       3'd5, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1});
    vecs.push_back('{"rem_by0",        3'd6, 32'd5,          32'd0,          5'd12, 32'd5,          1});
    vecs.push_back('{"div_ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  1});
    vecs.push_back('{"rem_ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1});
    vecs.push_back('{"mul_rd0",        3'd0, 32'd3,          32'd3,          5'd0,  32'd9,          MUL_LAT});

    // Reset state
    #12;
    chk("reset_outputs", {27'd0, busy, fin, wb_en, state_dbg}, 32'd0);
    chk("reset_rd", 32'(rd_o), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].exp, vecs[i].lat, 1'b0, 0);

    // Foreign op pulsed during CALC must be ignored
    run_op("pulse_in_calc", 3'd5, 32'd1000, 32'd9, 5'd5, ref_model(3'd5, 32'd1000, 32'd9), 33, 1'b0, 5);
    // md held high through DONE: DONE must still return to IDLE
    run_op("hold_through_done", 3'd4, 32'd77, 32'hFFFF_FFF5, 5'd21,
           ref_model(3'd4, 32'd77, 32'hFFFF_FFF5), 33, 1'b1, 0);

    // Asynchronous reset mid-divide aborts the op
    begin
      bit any_fin;
      @(negedge clk);
      md = 1'b1; op = 3'd4; a = 32'd12345; b = 32'd17; rd = 5'd2;
      @(posedge clk);
      #1 md = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {29'd0, busy, fin, wb_en}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      any_fin = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (fin || busy) any_fin = 1'b1;
      end
      chk("abort_no_finish", 32'(any_fin), 32'd0);
    end
    run_op("after_abort", 3'd6, 32'hFFFF_FF00, 32'd7, 5'd30, ref_model(3'd6, 32'hFFFF_FF00, 32'd7), 33, 1'b0, 0);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      logic [4:0]  r;
      f = 3'($urandom_range(0, 7));
      x = $urandom();
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        default: y = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      r = 5'($urandom_range(0, 31));
      run_op("random", f, x, y, r, ref_model(f, x, y), ref_lat(f, x, y), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
